// File: rtl/sr_latch_driver_if.sv
// Requester-side handshake bundle for sr_latch_driver.
//   set_req : level request to set the latch, held until ack
//   clr_req : level request to clear the latch, held until ack
//   ack     : one-cycle pulse, request consumed
//   err     : one-cycle pulse with ack, conflict or feedback timeout
//   busy    : sequencer is not idle
//   q_state : last confirmed latch value
// master = requester, slave = sr_latch_driver.
interface sr_latch_driver_if;
  logic set_req;
  logic clr_req;
  logic ack;
  logic err;
  logic busy;
  logic q_state;

  modport master (
    output set_req,
    output clr_req,
    input  ack,
    input  err,
    input  busy,
    input  q_state
  );

  modport slave (
    input  set_req,
    input  clr_req,
    output ack,
    output err,
    output busy,
    output q_state
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Sequencer driving the S/R/E inputs of a gated SR latch.
// Turns set/clear requests into width-controlled S or R pulses (never S=R=1),
// confirms the result from synchronized Q/Qbar feedback and answers with ack/err.
// Ports:
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   bus (slave)      : set_req/clr_req in, ack/err/busy/q_state out
//   s_out/r_out/e_out: latch drive, all registered
//   q_in/qbar_in     : latch feedback, asynchronous to clk
module sr_latch_driver #(
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  sr_latch_driver_if.slave   bus,
  output logic               s_out,
  output logic               r_out,
  output logic               e_out,
  input  logic               q_in,
  input  logic               qbar_in
);

  localparam int MAX_PG = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int MAX_C  = (MAX_PG > TIMEOUT_CYC) ? MAX_PG : TIMEOUT_CYC;
  localparam int CW     = $clog2(MAX_C + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_CHECK = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_target;
  logic          r_s;
  logic          r_r;
  logic          r_e;
  logic          r_ack;
  logic          r_err;
  logic          r_busy;
  logic          r_q_state;
  logic [1:0]    r_q_sync;
  logic [1:0]    r_qbar_sync;
  logic          w_match;

  assign s_out       = r_s;
  assign r_out       = r_r;
  assign e_out       = r_e;
  assign bus.ack     = r_ack;
  assign bus.err     = r_err;
  assign bus.busy    = r_busy;
  assign bus.q_state = r_q_state;

  // A latch output with Q==Qbar never matches either target, so it just waits for the timeout.
  assign w_match = (r_q_sync[1] == r_target) && (r_qbar_sync[1] == ~r_target);

  // Two-stage synchronizers for the asynchronous latch feedback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_sync    <= 2'b00;
      r_qbar_sync <= 2'b00;
    end else begin
      r_q_sync    <= {r_q_sync[0], q_in};
      r_qbar_sync <= {r_qbar_sync[0], qbar_in};
    end
  end

  // Sequencer FSM; every output is set from the state being entered so it is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_target  <= 1'b0;
      r_s       <= 1'b0;
      r_r       <= 1'b0;
      r_e       <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_q_state <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          r_cnt <= '0;
          // Only one of S/R is ever raised; a double request is refused without any drive.
          if (bus.set_req && !bus.clr_req) begin
            r_target <= 1'b1;
            r_s      <= 1'b1;
            r_e      <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ST_PULSE;
          end else if (bus.clr_req && !bus.set_req) begin
            r_target <= 1'b0;
            r_r      <= 1'b1;
            r_e      <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= ST_PULSE;
          end else if (bus.set_req && bus.clr_req) begin
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_GAP;
          end else begin
            r_busy <= 1'b0;
          end
        end

        ST_PULSE: begin
          // Drive was raised on entry, so PULSE_CYC-1 further edges give PULSE_CYC high cycles.
          if (r_cnt == CW'(PULSE_CYC - 1)) begin
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_e     <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_CHECK;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_CHECK: begin
          if (w_match) begin
            r_ack     <= 1'b1;
            r_q_state <= r_target;
            r_cnt     <= '0;
            r_state   <= ST_GAP;
          end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
            r_ack   <= 1'b1;
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_GAP: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          if (r_cnt == CW'(GAP_CYC - 1)) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
          r_e     <= 1'b0;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural gated SR latch model.
module tb_sr_latch_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_out;
  logic r_out;
  logic e_out;
  logic q_lat = 1'b0;
  logic qbar_lat;
  logic stuck = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  int   lat;
  logic seen;
  logic err_v;
  int   sc;
  int   rc;
  int   ec;
  int   gap;

  always #5 clk = ~clk;

  sr_latch_driver_if bus ();

  sr_latch_driver dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .s_out   (s_out),
    .r_out   (r_out),
    .e_out   (e_out),
    .q_in    (q_lat),
    .qbar_in (qbar_lat)
  );

  // Gated SR latch model with an optional stuck-at-0 Q.
  assign qbar_lat = ~q_lat;
  always @(s_out, r_out, e_out, stuck) begin
    if (stuck) q_lat = 1'b0;
    else if (e_out && s_out) q_lat = 1'b1;
    else if (e_out && r_out) q_lat = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive invariants on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("s_and_r", 32'(s_out & r_out), 32'd0);
      check("e_eq_s_or_r", 32'(e_out), 32'(s_out | r_out));
    end
  end

  task automatic wait_ack(output int l, output logic sn, output logic ev,
                          output int s_c, output int r_c, output int e_c);
    l = 0; sn = 1'b0; ev = 1'b0; s_c = 0; r_c = 0; e_c = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      s_c += int'(s_out);
      r_c += int'(r_out);
      e_c += int'(e_out);
      if (bus.ack) begin
        l  = i;
        sn = 1'b1;
        ev = bus.err;
        break;
      end
    end
  endtask

  initial begin
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s", 32'(s_out), 32'd0);
    check("rst_r", 32'(r_out), 32'd0);
    check("rst_e", 32'(e_out), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_q", 32'(bus.q_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // 1: set
    bus.set_req = 1'b1;
    wait_ack(lat, seen, err_v, sc, rc, ec);
    bus.set_req = 1'b0;
    check("t1_seen", 32'(seen), 32'd1);
    check("t1_lat", 32'(lat), 32'd6);
    check("t1_err", 32'(err_v), 32'd0);
    check("t1_scnt", 32'(sc), 32'd4);
    check("t1_rcnt", 32'(rc), 32'd0);
    check("t1_ecnt", 32'(ec), 32'd4);
    check("t1_q", 32'(bus.q_state), 32'd1);
    @(negedge clk);
    check("t1_ack_1cyc", 32'(bus.ack), 32'd0);
    @(negedge clk);

    // 2: clear
    bus.clr_req = 1'b1;
    wait_ack(lat, seen, err_v, sc, rc, ec);
    bus.clr_req = 1'b0;
    check("t2_seen", 32'(seen), 32'd1);
    check("t2_lat", 32'(lat), 32'd6);
    check("t2_err", 32'(err_v), 32'd0);
    check("t2_scnt", 32'(sc), 32'd0);
    check("t2_rcnt", 32'(rc), 32'd4);
    check("t2_q", 32'(bus.q_state), 32'd0);
    @(negedge clk);
    check("t2_busy_gap", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("t2_busy_idle", 32'(bus.busy), 32'd0);

    // 3: conflicting requests
    bus.set_req = 1'b1;
    bus.clr_req = 1'b1;
    wait_ack(lat, seen, err_v, sc, rc, ec);
    bus.set_req = 1'b0;
    bus.clr_req = 1'b0;
    check("t3_lat", 32'(lat), 32'd1);
    check("t3_err", 32'(err_v), 32'd1);
    check("t3_drive", 32'(sc + rc + ec), 32'd0);
    check("t3_q", 32'(bus.q_state), 32'd0);
    @(negedge clk);
    check("t3_ack_1cyc", 32'(bus.ack), 32'd0);
    check("t3_no_drive", 32'(e_out), 32'd0);
    repeat (2) @(negedge clk);

    // 4: stuck latch, feedback timeout
    stuck = 1'b1;
    bus.set_req = 1'b1;
    wait_ack(lat, seen, err_v, sc, rc, ec);
    bus.set_req = 1'b0;
    check("t4_lat", 32'(lat), 32'd21);
    check("t4_err", 32'(err_v), 32'd1);
    check("t4_scnt", 32'(sc), 32'd4);
    check("t4_q", 32'(bus.q_state), 32'd0);
    stuck = 1'b0;
    repeat (3) @(negedge clk);

    // 5: reset during the second pulse cycle
    bus.set_req = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_s_pre", 32'(s_out), 32'd1);
    rst_n = 1'b0;
    bus.set_req = 1'b0;
    #1;
    check("t5_s_rst", 32'(s_out), 32'd0);
    check("t5_e_rst", 32'(e_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_ack_rst", 32'(bus.ack), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_busy", 32'(bus.busy), 32'd0);
      check("t5_q", 32'(bus.q_state), 32'd0);
      check("t5_ack", 32'(bus.ack), 32'd0);
    end

    // 6: request held through ack restarts after the gap
    bus.set_req = 1'b1;
    wait_ack(lat, seen, err_v, sc, rc, ec);
    check("t6_lat", 32'(lat), 32'd6);
    check("t6_err", 32'(err_v), 32'd0);
    check("t6_q", 32'(bus.q_state), 32'd1);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_out) break;
      gap++;
    end
    check("t6_gap", 32'(gap), 32'd2);
    bus.set_req = 1'b0;
    wait_ack(lat, seen, err_v, sc, rc, ec);
    check("t6_seen2", 32'(seen), 32'd1);
    check("t6_err2", 32'(err_v), 32'd0);
    check("t6_q2", 32'(bus.q_state), 32'd1);
    repeat (3) @(negedge clk);
    check("t6_busy_end", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
